// File: rtl/alu_mc.sv
// Multi-cycle Hack-style ALU with valid/ready handshakes on both sides.
// Define ALU_MC_MUL_EN to add a WIDTH-cycle shift-add multiply mode (mul=1).
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cy_q, cy_d, ov_q, ov_d;

  logic [WIDTH-1:0] xz, yz, xp, yp, r, std_out;
  logic [WIDTH:0]   sum;
  logic             std_cy, std_ov;

  always_comb begin
    xz      = zx ? '0 : x;
    yz      = zy ? '0 : y;
    xp      = nx ? ~xz : xz;
    yp      = ny ? ~yz : yz;
    sum     = {1'b0, xp} + {1'b0, yp};
    r       = f ? sum[WIDTH-1:0] : (xp & yp);
    std_out = no ? ~r : r;
    std_cy  = f & sum[WIDTH];
    // Overflow: both addends share a sign that the sum does not.
    std_ov  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);
  end

`ifdef ALU_MC_MUL_EN
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_step;
  logic             no_q, no_d;
`else
  logic unused_mul;
  assign unused_mul = mul;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    out_d   = out_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
`ifdef ALU_MC_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
    acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MC_MUL_EN
          if (mul) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = xp;
            mplier_d = yp;
            cnt_d    = '0;
            no_d     = no;
          end else
`endif
          begin
            state_d = DONE;
            out_d   = std_out;
            cy_d    = std_cy;
            ov_d    = std_ov;
          end
        end
      end
`ifdef ALU_MC_MUL_EN
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last of WIDTH steps writes the result directly so DONE follows at once.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = no_q ? ~acc_step : acc_step;
          cy_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ALU_MC_MUL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
`ifdef ALU_MC_MUL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

`ifdef ALU_MC_MUL_EN
  // NOTE: multiply datapath is left unreset; it is fully loaded on every accept.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    no_q     <= no_d;
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign zr        = (out_q == '0);
  assign ng        = out_q[WIDTH-1];
  assign cy        = cy_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: transaction-level timing/value model plus
// directed literal cases and a randomized handshake/reset soak.
module tb_alu_mc;
  localparam int W = 16;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mul, out_valid, out_ready;
  logic [W-1:0] x, y, out;
  logic [5:0]   ctrl;   // {zx, nx, zy, ny, f, no}
  logic         zr, ng, cy, ov, busy;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(ctrl[5]), .nx(ctrl[4]), .zy(ctrl[3]), .ny(ctrl[2]),
    .f(ctrl[1]), .no(ctrl[0]), .mul(mul), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov),
    .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result value, flags and latency of one operation from the rules.
  function automatic void model_op(input logic [W-1:0] xv, yv, input logic [5:0] c,
                                   input logic m, output logic [W-1:0] o,
                                   output logic co, vo, output int lat);
    longint unsigned mask = (64'd1 << W) - 1;
    longint unsigned xa, ya, xpv, ypv, s, rv;
    longint          sx, sy, ss;
    xa  = c[5] ? 0 : longint'(xv);
    xpv = c[4] ? (~xa & mask) : xa;
    ya  = c[3] ? 0 : longint'(yv);
    ypv = c[2] ? (~ya & mask) : ya;
    if (MUL_EN && m) begin
      rv  = (xpv * ypv) & mask;
      o   = W'(c[0] ? (~rv & mask) : rv);
      co  = 1'b0;
      vo  = 1'b0;
      lat = W + 1;
    end else begin
      s   = xpv + ypv;
      rv  = c[1] ? (s & mask) : (xpv & ypv);
      o   = W'(c[0] ? (~rv & mask) : rv);
      sx  = (xpv >= (64'd1 << (W - 1))) ? longint'(xpv) - longint'(64'd1 << W) : longint'(xpv);
      sy  = (ypv >= (64'd1 << (W - 1))) ? longint'(ypv) - longint'(64'd1 << W) : longint'(ypv);
      ss  = sx + sy;
      co  = c[1] && (s > mask);
      vo  = c[1] && ((ss > longint'((64'd1 << (W - 1)) - 1)) || (ss < -longint'(64'd1 << (W - 1))));
      lat = 1;
    end
  endfunction

  // Model state: one pending operation whose result becomes visible at edge m_ready.
  int           cyc = 0;
  bit           m_init = 0, m_pend = 0, m_rst_known = 0;
  int           m_ready = 0;
  logic [W-1:0] m_out;
  logic         m_cy, m_ov;

  always @(posedge clk) begin
    int lat;
    cyc++;
    if (rst_n === 1'b0) begin
      m_init = 1; m_pend = 0; m_rst_known = 1;
      m_out = '0; m_cy = 0; m_ov = 0;
    end else if (m_pend) begin
      if (cyc > m_ready && out_ready) m_pend = 0;
    end else if (in_valid) begin
      model_op(x, y, ctrl, mul, m_out, m_cy, m_ov, lat);
      m_pend = 1; m_rst_known = 0;
      m_ready = cyc + lat - 1;
    end
  end

  // Compare DUT against the model one time unit after every edge.
  always @(posedge clk) begin
    bit exp_valid;
    #1;
    if (m_init) begin
      exp_valid = m_pend && (cyc >= m_ready);
      check("in_ready", in_ready, !m_pend);
      check("busy", busy, m_pend);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid || m_rst_known) begin
        check("out", out, m_out);
        check("zr", zr, m_out == '0);
        check("ng", ng, m_out[W-1]);
        check("cy", cy, m_cy);
        check("ov", ov, m_ov);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] xv, yv, input logic [5:0] c, input logic m);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("send_ready", in_ready, 1'b1);
    x = xv; y = yv; ctrl = c; mul = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); ctrl = 6'($urandom); mul = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat, output bit all_busy);
    lat = 1; all_busy = busy;
    while (!out_valid && lat < 100) begin tick(); lat++; all_busy &= busy; end
  endtask

  task automatic release_result();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic std_case(input string nm, input logic [W-1:0] xv, yv, input logic [5:0] c,
                          input logic [W-1:0] eo, input logic ez, en, ec, ev);
    int lat; bit ab;
    send(xv, yv, c, 1'b0);
    wait_valid(lat, ab);
    check({nm, "_lat"}, lat, 1);
    check({nm, "_out"}, out, eo);
    check({nm, "_zr"}, zr, ez);
    check({nm, "_ng"}, ng, en);
    check({nm, "_cy"}, cy, ec);
    check({nm, "_ov"}, ov, ev);
    release_result();
  endtask

  initial begin
    int lat; bit ab, stale;
    logic [W-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mul = 1'b0;
    x = '0; y = '0; ctrl = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out", out, 16'h0000);
    check("rst_zr", zr, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    std_case("add_5_3",   16'd5,    16'd3,    6'b000010, 16'h0008, 0, 0, 0, 0);
    std_case("add_ovf",   16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 0, 1, 0, 1);
    std_case("add_carry", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1, 0, 1, 0);
    std_case("sub_9_4",   16'd9,    16'd4,    6'b010011, 16'h0005, 0, 0, 0, 0);
    std_case("zero",      16'h1234, 16'h5678, 6'b101010, 16'h0000, 1, 0, 0, 0);
    std_case("and",       16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 0, 0, 0, 0);

    // Result held with out_ready low, then released.
    send(16'd9, 16'd4, 6'b010011, 1'b0);
    wait_valid(lat, ab);
    held = out;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || out !== held || in_ready || zr || ng) stale = 1'b1;
    end
    check("hold_stable", stale, 1'b0);
    check("hold_out", out, 16'h0005);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("release_ready", in_ready, 1'b1);
    check("release_valid", out_valid, 1'b0);

`ifdef ALU_MC_MUL_EN
    send(16'd300, 16'd200, 6'b000000, 1'b1);
    wait_valid(lat, ab);
    check("mul_lat", lat, 17);
    check("mul_out", out, 16'hEA60);
    check("mul_ng", ng, 1'b1);
    check("mul_busy", ab, 1'b1);
    release_result();

    send(16'd300, 16'd200, 6'b000000, 1'b1);
    repeat (7) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
`else
    send(16'd5, 16'd3, 6'b000010, 1'b1);
    wait_valid(lat, ab);
    check("mul_ignored_lat", lat, 1);
    check("mul_ignored_out", out, 16'h0008);
    release_result();

    send(16'd300, 16'd200, 6'b000010, 1'b0);
    wait_valid(lat, ab);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
`endif
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_out", out, 16'h0000);
    check("abort_zr", zr, 1'b1);
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (out_valid) stale = 1'b1; end
    check("abort_no_stale", stale, 1'b0);

    // Randomized soak: the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = 1'($urandom);
      mul       = 1'($urandom);
      ctrl      = 6'($urandom);
      case ($urandom_range(0, 5))
        0: x = 16'h7FFF;
        1: x = 16'hFFFF;
        2: x = 16'h0000;
        default: x = W'($urandom);
      endcase
      y     = ($urandom_range(0, 4) == 0) ? 16'h0001 : W'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
